// File: rtl/prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : prod_accumulator
//  Purpose  : Sums a frame of N_TERMS unsigned 7-bit multiplier products over
//             a valid/ready handshake and presents the frame total together
//             with a sticky carry-out (overflow) flag.
//  Revision : 1.0 - initial release
// ============================================================================
module prod_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [6:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);
    localparam logic [ACC_W-7:0] c_prod_pad = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;

    logic [ACC_W:0]    w_prod_ext;
    logic [ACC_W:0]    w_sum;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_accept;

    // Product widened by one bit so the top bit of the sum is the carry out.
    assign w_prod_ext = {c_prod_pad, prod};
    assign w_sum      = {1'b0, r_acc} + w_prod_ext;
    assign w_cnt_nxt  = r_cnt + c_one_cnt;

    // No beat is taken while a total is waiting, during a flush, or in reset.
    assign prod_ready = rst & ~clear & (r_state != S_HOLD);
    assign w_accept   = prod_valid & prod_ready;

    assign acc_out   = r_acc;
    assign ovf       = r_ovf;
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);

    // Frame sequencer: collect N_TERMS beats, then hold the total until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= w_prod_ext[ACC_W-1:0];
                        r_cnt   <= c_one_cnt;
                        r_ovf   <= 1'b0;
                        r_state <= (N_TERMS == 1) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_last_cnt) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // ovf is kept so it stays readable until the next frame starts.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prod_accumulator
//  Purpose  : Self-checking bench for prod_accumulator: a default instance
//             (N_TERMS=4, ACC_W=9) and a narrow instance (N_TERMS=3, ACC_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prod_accumulator;

    localparam int NA = 4;
    localparam int WA = 9;
    localparam int NB = 3;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       clear [2];
    logic       valid [2];
    logic       oready[2];
    logic [6:0] prod  [2];

    logic          a_ready, a_ovf, a_ovalid, a_busy;
    logic [WA-1:0] a_acc;
    logic          b_ready, b_ovf, b_ovalid, b_busy;
    logic [WB-1:0] b_acc;

    int checks   = 0;
    int failures = 0;

    prod_accumulator #(.N_TERMS(NA), .ACC_W(WA)) dut_a (
        .clk(clk), .rst(rst), .clear(clear[0]), .prod(prod[0]),
        .prod_valid(valid[0]), .prod_ready(a_ready), .acc_out(a_acc),
        .ovf(a_ovf), .out_valid(a_ovalid), .out_ready(oready[0]), .busy(a_busy)
    );

    prod_accumulator #(.N_TERMS(NB), .ACC_W(WB)) dut_b (
        .clk(clk), .rst(rst), .clear(clear[1]), .prod(prod[1]),
        .prod_valid(valid[1]), .prod_ready(b_ready), .acc_out(b_acc),
        .ovf(b_ovf), .out_valid(b_ovalid), .out_ready(oready[1]), .busy(b_busy)
    );

    typedef struct {
        int s;
        int n;
        int v[4];
        int gap[4];
        int acc;
        int ovf;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input int s, input int n,
                                input int a, input int b, input int c, input int d,
                                input int g0, input int g1, input int g2, input int g3,
                                input int acc, input int ovf);
        vec_t t;
        t.s = s; t.n = n;
        t.v[0] = a; t.v[1] = b; t.v[2] = c; t.v[3] = d;
        t.gap[0] = g0; t.gap[1] = g1; t.gap[2] = g2; t.gap[3] = g3;
        t.acc = acc; t.ovf = ovf;
        return t;
    endfunction

    function automatic int get_ready(input int s);
        return (s == 0) ? int'(a_ready) : int'(b_ready);
    endfunction
    function automatic int get_ovf(input int s);
        return (s == 0) ? int'(a_ovf) : int'(b_ovf);
    endfunction
    function automatic int get_ovalid(input int s);
        return (s == 0) ? int'(a_ovalid) : int'(b_ovalid);
    endfunction
    function automatic int get_busy(input int s);
        return (s == 0) ? int'(a_busy) : int'(b_busy);
    endfunction
    function automatic int get_acc(input int s);
        return (s == 0) ? int'(a_acc) : int'(b_acc);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers the beats of t one per cycle (with idle gaps before each beat).
    task automatic send_beats(input vec_t t, input string nm);
        for (int i = 0; i < t.n; i++) begin
            for (int g = 0; g < t.gap[i]; g++) begin
                valid[t.s] = 1'b0;
                #1;
                if (i > 0) chk({nm, " busy in gap"}, get_busy(t.s), 1);
                step();
            end
            valid[t.s] = 1'b1;
            prod[t.s]  = 7'(t.v[i]);
            #1;
            chk({nm, " prod_ready"}, get_ready(t.s), 1);
            if (i > 0) chk({nm, " busy"}, get_busy(t.s), 1);
            step();
        end
        valid[t.s] = 1'b0;
    endtask

    // Checks the presented total, then lets it transfer (out_ready must be 1).
    task automatic take_total(input int s, input int acc, input int ovf, input string nm);
        #1;
        chk({nm, " out_valid"}, get_ovalid(s), 1);
        chk({nm, " acc_out"},   get_acc(s),    acc);
        chk({nm, " ovf"},       get_ovf(s),    ovf);
        chk({nm, " ready in hold"}, get_ready(s), 0);
        step();
        chk({nm, " out_valid after xfer"}, get_ovalid(s), 0);
        chk({nm, " busy after xfer"},      get_busy(s),   0);
        chk({nm, " acc after xfer"},       get_acc(s),    0);
    endtask

    // Random traffic against a frame-level model: a list of collected beats
    // and one pending total.
    task automatic rand_run(input int s, input int ncyc);
        int q[$];
        bit pend = 1'b0;
        int etot = 0;
        int eovf = 0;
        int n    = (s == 0) ? NA : NB;
        int w    = (s == 0) ? WA : WB;
        int sum;
        for (int c = 0; c < ncyc; c++) begin
            clear[s]  = (c == 0) || ($urandom_range(0, 99) < 3);
            valid[s]  = ($urandom_range(0, 99) < 70);
            prod[s]   = 7'($urandom_range(0, 127));
            oready[s] = 1'($urandom_range(0, 1));
            #1;
            chk("rnd prod_ready", get_ready(s), int'(!clear[s] && !pend));
            chk("rnd out_valid",  get_ovalid(s), int'(pend));
            chk("rnd busy",       get_busy(s), int'(pend || q.size() > 0));
            if (pend) begin
                chk("rnd acc_out", get_acc(s), etot);
                chk("rnd ovf",     get_ovf(s), eovf);
            end
            step();
            if (clear[s]) begin
                q.delete();
                pend = 1'b0;
            end else if (pend) begin
                if (oready[s]) pend = 1'b0;
            end else if (valid[s]) begin
                q.push_back(int'(prod[s]));
                if (q.size() == n) begin
                    sum = 0;
                    foreach (q[k]) sum += q[k];
                    etot = sum % (1 << w);
                    eovf = (sum >= (1 << w)) ? 1 : 0;
                    pend = 1'b1;
                    q.delete();
                end
            end
        end
        clear[s]  = 1'b0;
        valid[s]  = 1'b0;
        oready[s] = 1'b1;
        step();
        step();
    endtask

    initial begin
        vec_t t;
        for (int s = 0; s < 2; s++) begin
            clear[s] = 1'b0; valid[s] = 1'b0; oready[s] = 1'b0; prod[s] = '0;
        end

        tbl[0] = mk(0, 4, 105, 105, 105, 105, 0, 0, 0, 0, 420, 0);
        tbl[1] = mk(0, 4,   7,   0,  14,  21, 0, 1, 3, 2,  42, 0);
        tbl[2] = mk(0, 4,   0,   0,   0,   0, 0, 0, 1, 0,   0, 0);
        tbl[3] = mk(0, 4, 127, 127, 127, 127, 0, 2, 0, 0, 508, 0);
        tbl[4] = mk(1, 3, 105, 105, 105,   0, 0, 0, 0, 0,  59, 1);
        tbl[5] = mk(1, 3,   1,   2,   3,   0, 0, 0, 0, 0,   6, 0);
        tbl[6] = mk(1, 3, 127, 127,   2,   0, 0, 1, 0, 0,   0, 1);
        tbl[7] = mk(1, 3, 127, 127,   1,   0, 0, 0, 0, 0, 255, 0);
        tbl[8] = mk(1, 3,   0,   0,   0,   0, 2, 0, 1, 0,   0, 0);

        // Reset state while rst is held low
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst prod_ready", get_ready(s),  0);
            chk("rst out_valid",  get_ovalid(s), 0);
            chk("rst busy",       get_busy(s),   0);
            chk("rst acc_out",    get_acc(s),    0);
            chk("rst ovf",        get_ovf(s),    0);
        end
        step();
        rst = 1'b1;
        oready[0] = 1'b1;
        oready[1] = 1'b1;
        step();

        // Table-driven frames with immediate transfer
        for (int i = 0; i < 9; i++) begin
            send_beats(tbl[i], $sformatf("vec%0d", i));
            take_total(tbl[i].s, tbl[i].acc, tbl[i].ovf, $sformatf("vec%0d", i));
        end

        // Sticky ovf survives the transfer and clears on the next first accept
        t = mk(1, 3, 105, 105, 105, 0, 0, 0, 0, 0, 59, 1);
        send_beats(t, "ovfhold");
        take_total(1, 59, 1, "ovfhold");
        chk("ovfhold ovf in idle", get_ovf(1), 1);
        valid[1] = 1'b1; prod[1] = 7'd1;
        step();
        chk("ovfhold ovf after first accept", get_ovf(1), 0);
        chk("ovfhold busy", get_busy(1), 1);
        t = mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        send_beats(t, "ovfhold2");
        take_total(1, 3, 0, "ovfhold2");

        // Backpressure: total held five cycles with a beat offered meanwhile
        oready[0] = 1'b0;
        t = mk(0, 4, 1, 2, 3, 4, 0, 0, 0, 0, 10, 0);
        send_beats(t, "bp");
        valid[0] = 1'b1; prod[0] = 7'd99;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp out_valid", get_ovalid(0), 1);
            chk("bp acc_out",   get_acc(0),    10);
            chk("bp prod_ready", get_ready(0), 0);
            chk("bp busy",      get_busy(0),   1);
            step();
        end
        oready[0] = 1'b1;
        #1;
        chk("bp out_valid at xfer", get_ovalid(0), 1);
        chk("bp ready at xfer",     get_ready(0),  0);
        step();
        chk("bp out_valid after xfer", get_ovalid(0), 0);
        chk("bp busy after xfer",      get_busy(0),   0);
        chk("bp ready after xfer",     get_ready(0),  1);
        step();
        chk("bp new frame busy", get_busy(0), 1);
        t = mk(0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 102, 0);
        send_beats(t, "bp2");
        take_total(0, 102, 0, "bp2");

        // clear after two beats drops the partial sum and the offered beat
        t = mk(0, 2, 50, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        send_beats(t, "clr");
        clear[0] = 1'b1; valid[0] = 1'b1; prod[0] = 7'd50;
        #1;
        chk("clr prod_ready", get_ready(0), 0);
        step();
        clear[0] = 1'b0; valid[0] = 1'b0;
        chk("clr busy",      get_busy(0),   0);
        chk("clr out_valid", get_ovalid(0), 0);
        chk("clr acc_out",   get_acc(0),    0);
        t = mk(0, 4, 1, 1, 1, 1, 0, 0, 0, 0, 4, 0);
        send_beats(t, "clr2");
        take_total(0, 4, 0, "clr2");

        // Asynchronous reset in the middle of a frame
        t = mk(0, 2, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        send_beats(t, "arst");
        #2;
        rst = 1'b0;
        #1;
        chk("arst busy",       get_busy(0),   0);
        chk("arst out_valid",  get_ovalid(0), 0);
        chk("arst acc_out",    get_acc(0),    0);
        chk("arst prod_ready", get_ready(0),  0);
        chk("arst ovf",        get_ovf(0),    0);
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        t = mk(0, 4, 10, 10, 10, 10, 0, 0, 0, 0, 40, 0);
        send_beats(t, "arst2");
        take_total(0, 40, 0, "arst2");

        // Randomized traffic on both instances
        rand_run(0, 400);
        rand_run(1, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential accumulator that sits directly downstream of the 3x4 array multiplier and consumes its 7-bit products.
- Sums a frame of N_TERMS products using a valid/ready handshake and presents the frame total downstream.
- Reports a sticky overflow flag for the frame.
- Used to build dot-product / MAC results from the combinational multiplier.

Parameters:
- N_TERMS, 4, number of products summed per frame (>=1).
- ACC_W, 9, accumulator width in bits (>=7). The sum wraps modulo 2^ACC_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame flush, active-high.
- prod  input  7  unsigned product from the multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  frame total; meaningful only while out_valid=1.
- ovf  output  1  sticky overflow for the presented frame; meaningful while out_valid=1.
- out_valid  output  1  frame total available.
- out_ready  input  1  downstream takes the total.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - out_valid=0, acc_out=0, busy=0.
  - prod_ready=0 while rst=0.
- Accept rule: a beat is accepted on a rising edge where prod_valid=1 and prod_ready=1.
- prod_ready = rst & ~clear & (state != HOLD). It is combinational and does not depend on prod_valid.
- Internal counter cnt has width $clog2(N_TERMS+1).
- Zero-extend prod to ACC_W+1 bits before adding. Bit ACC_W of the sum is the carry.
- States:
  - IDLE: on accept, acc<=prod, cnt<=1, ovf<=0. Next state is HOLD if N_TERMS==1, otherwise ACCUM. Without an accept, stay in IDLE.
  - ACCUM: on accept, acc<=acc+prod (low ACC_W bits), ovf<=ovf|carry, cnt<=cnt+1. Go to HOLD when cnt+1==N_TERMS. Idle cycles (prod_valid=0) hold all state; there is no timeout.
  - HOLD: out_valid=1. acc_out=acc and ovf stay stable until the transfer.
    - On out_ready=1: the transfer occurs, and next cycle state=IDLE, out_valid=0, acc=0, cnt=0.
    - ovf holds its value until the next frame's first accept clears it.
- Latency: out_valid rises in the cycle after the N_TERMS-th accept edge. Minimum frame period is N_TERMS+1 cycles, because no beat is accepted in HOLD, including on the transfer cycle.
- acc_out is driven from the acc register in all states (0 in IDLE after a transfer). Downstream must qualify it with out_valid.
- clear=1 at an edge: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0. clear has priority over accept and over the HOLD transfer. A beat offered in that cycle is dropped, since prod_ready=0.
- Reset asserted mid-frame or mid-HOLD: the partial sum and any pending total are discarded. No output is produced for that frame.
- prod=0 beats count as terms.
- ACC_W wrap: the low ACC_W bits are kept and ovf=1 if any carry occurred in the frame.

Test Plan:
- Defaults; 4 beats of prod=105 back-to-back; out_ready=1 → out_valid high in cycle 5 after the first accept, acc_out=420, ovf=0, back to IDLE the next cycle.
- ACC_W=8, N_TERMS=3; prod=105,105,105 → acc_out=59 (315 mod 256), ovf=1. Next frame prod=1,2,3 → acc_out=6, ovf=0.
- Backpressure: complete a frame with out_ready=0 for 5 cycles → out_valid=1, acc_out stable, prod_ready=0, prod_valid beats not consumed. Then out_ready=1 → one transfer, and the next beat starts a new frame.
- Gapped input: beats 7,0,14,21 separated by 1-3 idle cycles → acc_out=42; busy stays 1 from the first accept until the transfer.
- clear after 2 accepted beats (50,50), then 4 beats of 1 → acc_out=4. The beat offered with clear=1 is not accepted.
- rst driven low asynchronously mid-cycle during ACCUM → outputs go to reset values immediately. After release, a frame of 4×10 → acc_out=40.
